// File: rtl/uart_bridge_pkg.sv
// Shared encodings and sizing for the uart <-> AES block bridge.
// Imported by the RX path (top) and the TX block serializer.
package uart_bridge_pkg;

  localparam int BLOCK_BYTES_DEF = 16;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(BLOCK_BYTES_DEF);

  typedef enum logic {
    R_COLLECT = 1'b0,
    R_HOLD    = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE      = 2'd0,
    T_LOAD      = 2'd1,
    T_WAIT_BUSY = 2'd2,
    T_WAIT_IDLE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/block_serializer.sv
// TX half of the bridge: latches one block and feeds it MSB byte first
// into the uart transmitter using its wr_en / tx_busy handshake.
module block_serializer
  import uart_bridge_pkg::*;
#(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [8*BLOCK_BYTES-1:0] i_blk,
  input  logic                     i_blk_valid,
  output logic                     o_blk_ready,
  input  logic                     i_tx_busy,
  output logic                     o_tx_wr_en,
  output logic [7:0]               o_tx_data
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int CW = cnt_width(BLOCK_BYTES);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);

  tx_state_e       r_state;
  tx_state_e       w_next;
  logic [W-1:0]    r_shift;
  logic [CW-1:0]   r_cnt;
  logic            r_wr_en;
  logic            r_ready;
  logic            w_accept;
  logic            w_fire;
  logic            w_done_byte;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= T_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      T_IDLE:      if (w_accept)   w_next = T_LOAD;
      T_LOAD:      if (!i_tx_busy) w_next = T_WAIT_BUSY;
      T_WAIT_BUSY: if (i_tx_busy)  w_next = T_WAIT_IDLE;
      T_WAIT_IDLE:
        if (!i_tx_busy)
          w_next = (r_cnt == LAST) ? T_IDLE : T_LOAD;
      default:     w_next = T_IDLE;
    endcase
  end

  always_comb begin
    w_accept    = (r_state == T_IDLE) && r_ready && i_blk_valid;
    w_fire      = (r_state == T_LOAD) && !i_tx_busy;
    w_done_byte = (r_state == T_WAIT_IDLE) && !i_tx_busy;
  end

  // A byte only counts as sent once busy has risen and fallen again.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_wr_en <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_wr_en <= w_fire;
      r_ready <= (w_next == T_IDLE);
      if (w_accept) begin
        r_shift <= i_blk;
        r_cnt   <= '0;
      end else if (w_done_byte) begin
        r_shift <= {r_shift[W-9:0], 8'h00};
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  assign o_blk_ready = r_ready;
  assign o_tx_wr_en  = r_wr_en;
  assign o_tx_data   = r_shift[W-1 -: 8];

endmodule

// File: rtl/uart_block_bridge.sv
// Byte/block adapter between the uart byte ports and the AES core.
// RX assembles blocks inline here; TX is delegated to block_serializer.
module uart_block_bridge
  import uart_bridge_pkg::*;
#(
  parameter int BLOCK_BYTES    = BLOCK_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     rx_rdy,
  input  logic [7:0]               rx_data,
  output logic                     rx_rdy_clr,
  input  logic                     tx_busy,
  output logic                     tx_wr_en,
  output logic [7:0]               tx_data,
  output logic [8*BLOCK_BYTES-1:0] blk_out,
  output logic                     blk_out_valid,
  input  logic                     blk_out_ready,
  input  logic [8*BLOCK_BYTES-1:0] blk_in,
  input  logic                     blk_in_valid,
  output logic                     blk_in_ready,
  output logic                     rx_frame_drop
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int CW = cnt_width(BLOCK_BYTES);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  rx_state_e      r_rx_state;
  rx_state_e      w_rx_next;
  logic [W-1:0]   r_rx_shift;
  logic [CW-1:0]  r_rx_cnt;
  logic [TW-1:0]  r_to_cnt;
  logic           r_rdy_clr;
  logic           r_valid;
  logic           r_drop;
  logic           w_cap;
  logic           w_last;
  logic           w_release;
  logic           w_to_run;
  logic           w_to_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rx_state <= R_COLLECT;
    else          r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    unique case (r_rx_state)
      R_COLLECT: if (w_last)    w_rx_next = R_HOLD;
      R_HOLD:    if (w_release) w_rx_next = R_COLLECT;
      default:   w_rx_next = R_COLLECT;
    endcase
  end

  // rdy is still high while clr is out; skipping that cycle avoids a re-read.
  always_comb begin
    w_cap     = (r_rx_state == R_COLLECT) && rx_rdy && !r_rdy_clr;
    w_last    = w_cap && (r_rx_cnt == LAST);
    w_release = (r_rx_state == R_HOLD) && blk_out_ready;
    w_to_run  = TO_EN && (r_rx_state == R_COLLECT) &&
                (r_rx_cnt != '0) && !w_cap;
    w_to_fire = w_to_run && (r_to_cnt == TO_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_shift <= '0;
      r_rx_cnt   <= '0;
      r_to_cnt   <= '0;
      r_rdy_clr  <= 1'b0;
      r_valid    <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_rdy_clr <= w_cap;
      r_drop    <= w_to_fire;
      if (w_cap)
        r_rx_shift <= {r_rx_shift[W-9:0], rx_data};
      if (w_cap)
        r_rx_cnt <= r_rx_cnt + CW'(1);
      else if (w_release || w_to_fire)
        r_rx_cnt <= '0;
      if (w_last)
        r_valid <= 1'b1;
      else if (w_release)
        r_valid <= 1'b0;
      if (w_to_fire || !w_to_run)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign rx_rdy_clr    = r_rdy_clr;
  assign blk_out       = r_rx_shift;
  assign blk_out_valid = r_valid;
  assign rx_frame_drop = r_drop;

  block_serializer #(
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_ser (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_blk       (blk_in),
    .i_blk_valid (blk_in_valid),
    .o_blk_ready (blk_in_ready),
    .i_tx_busy   (tx_busy),
    .o_tx_wr_en  (tx_wr_en),
    .o_tx_data   (tx_data)
  );

endmodule

// File: tb/tb_uart_block_bridge.sv
// Bench for uart_block_bridge: behavioural uart rx/tx responders
// plus block and byte scoreboards.
module tb_uart_block_bridge;

  localparam int BB = 16;
  localparam int W  = 8 * BB;
  localparam int TO = 100;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx_rdy = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_rdy_clr;
  logic         tx_busy = 1'b0;
  logic         tx_wr_en;
  logic [7:0]   tx_data;
  logic [W-1:0] blk_out;
  logic         blk_out_valid;
  logic         blk_out_ready = 1'b0;
  logic [W-1:0] blk_in = '0;
  logic         blk_in_valid = 1'b0;
  logic         blk_in_ready;
  logic         rx_frame_drop;

  always #5 clock = ~clock;

  uart_block_bridge #(
    .BLOCK_BYTES    (BB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx_rdy        (rx_rdy),
    .rx_data       (rx_data),
    .rx_rdy_clr    (rx_rdy_clr),
    .tx_busy       (tx_busy),
    .tx_wr_en      (tx_wr_en),
    .tx_data       (tx_data),
    .blk_out       (blk_out),
    .blk_out_valid (blk_out_valid),
    .blk_out_ready (blk_out_ready),
    .blk_in        (blk_in),
    .blk_in_valid  (blk_in_valid),
    .blk_in_ready  (blk_in_ready),
    .rx_frame_drop (rx_frame_drop)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   rx_src[$];
  logic [W-1:0] rx_exp[$];
  logic [7:0]   tx_exp[$];

  int tx_len    = 4;
  int tx_left   = 0;
  int clr_cnt   = 0;
  int valid_cyc = 0;
  int wr_cnt    = 0;
  int drop_cnt  = 0;
  int idle_n    = 0;
  int drop_at   = -1;
  bit armed     = 1'b1;
  bit seen_rise = 1'b0;

  // uart receiver: presents one byte, clears rdy on the rdy_clr edge
  always @(posedge clock) begin
    if (rx_rdy_clr)
      rx_rdy <= 1'b0;
    else if (!rx_rdy && rx_src.size() > 0) begin
      rx_data <= rx_src.pop_front();
      rx_rdy  <= 1'b1;
    end
  end

  // uart transmitter: busy for tx_len clocks per byte, no reset
  always @(posedge clock) begin
    if (tx_wr_en && !tx_busy) begin
      tx_busy <= 1'b1;
      tx_left <= tx_len;
    end else if (tx_busy) begin
      if (tx_left <= 1) tx_busy <= 1'b0;
      else              tx_left <= tx_left - 1;
    end
  end

  always @(negedge clock) begin
    logic [W-1:0] eb;
    logic [7:0]   e8;
    if (rx_rdy_clr) begin
      clr_cnt++;
      idle_n = 0;
    end else begin
      idle_n++;
    end
    if (rx_frame_drop) begin
      drop_cnt++;
      drop_at = idle_n;
    end
    if (blk_out_valid) valid_cyc++;
    if (blk_out_valid && blk_out_ready) begin
      n_tests++;
      if (rx_exp.size() == 0) begin
        n_fail++;
        $display("FAIL rx_block: got unexpected block %h", blk_out);
      end else begin
        eb = rx_exp.pop_front();
        if (blk_out !== eb) begin
          n_fail++;
          $display("FAIL rx_block: got %h expected %h", blk_out, eb);
        end
      end
    end
    if (tx_busy) seen_rise = 1'b1;
    else if (seen_rise) begin
      armed     = 1'b1;
      seen_rise = 1'b0;
    end
    if (tx_wr_en) begin
      wr_cnt++;
      n_tests++;
      if (tx_exp.size() == 0) begin
        n_fail++;
        $display("FAIL tx_byte: got unexpected byte %h", tx_data);
      end else begin
        e8 = tx_exp.pop_front();
        if (tx_data !== e8 || tx_busy !== 1'b0 || !armed) begin
          n_fail++;
          $display("FAIL tx_byte: got %h busy=%b armed=%b expected %h busy=0 armed=1",
                   tx_data, tx_busy, armed, e8);
        end
      end
      armed = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic wait_queues(input bit rx, input bit tx,
                             input int lim, output bit ok);
    int k = 0;
    while (((rx && rx_exp.size() != 0) || (tx && tx_exp.size() != 0))
           && k < lim) begin
      @(negedge clock);
      k++;
    end
    ok = !((rx && rx_exp.size() != 0) || (tx && tx_exp.size() != 0));
  endtask

  task automatic send_block(input logic [W-1:0] b, output bit ok);
    int k = 0;
    ok = 1'b0;
    @(posedge clock); #1;
    blk_in       = b;
    blk_in_valid = 1'b1;
    while (!ok && k < 300) begin
      @(negedge clock);
      if (blk_in_ready) ok = 1'b1;
      k++;
    end
    @(posedge clock); #1;
    blk_in_valid = 1'b0;
  endtask

  task automatic push_bytes(input logic [W-1:0] b, input int n, input bit to_tx);
    logic [W-1:0] t = b;
    for (int i = 0; i < n; i++) begin
      if (to_tx) tx_exp.push_back(t[W-1 -: 8]);
      else       rx_src.push_back(t[W-1 -: 8]);
      t = t << 8;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_tests++;
    if ({tx_wr_en, rx_rdy_clr, blk_out_valid, blk_in_ready, rx_frame_drop} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {tx_wr_en, rx_rdy_clr, blk_out_valid, blk_in_ready, rx_frame_drop});
    end
    n_tests++;
    if (blk_out !== '0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got blk_out=%h tx_data=%h expected 0", blk_out, tx_data);
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (blk_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b expected 0", blk_in_ready);
    end
    @(posedge clock); #1;
    n_tests++;
    if (blk_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge: got %b expected 1", blk_in_ready);
    end
  endtask

  task automatic test_rx_basic();
    int c0, v0;
    bit ok;
    @(posedge clock); #1;
    blk_out_ready = 1'b1;
    c0 = clr_cnt;
    v0 = valid_cyc;
    rx_exp.push_back(128'h000102030405060708090A0B0C0D0E0F);
    for (int i = 0; i < 16; i++) rx_src.push_back(8'(i));
    wait_queues(1'b1, 1'b0, 500, ok);
    repeat (3) @(negedge clock);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rx_basic_done: got %0d blocks pending expected 0", rx_exp.size());
    end
    n_tests++;
    if (clr_cnt - c0 != 16) begin
      n_fail++;
      $display("FAIL rx_basic_clr: got %0d pulses expected 16", clr_cnt - c0);
    end
    n_tests++;
    if (valid_cyc - v0 != 1) begin
      n_fail++;
      $display("FAIL rx_basic_valid: got %0d cycles expected 1", valid_cyc - v0);
    end
  endtask

  task automatic test_hold();
    int c0, k;
    int bad = 0;
    bit ok;
    @(posedge clock); #1;
    blk_out_ready = 1'b0;
    c0 = clr_cnt;
    rx_exp.push_back(128'h101112131415161718191A1B1C1D1E1F);
    rx_exp.push_back(128'hAA505152535455565758595A5B5C5D5E);
    for (int i = 0; i < 16; i++) rx_src.push_back(8'h10 + 8'(i));
    rx_src.push_back(8'hAA);
    for (int i = 0; i < 15; i++) rx_src.push_back(8'h50 + 8'(i));
    k = 0;
    while (!blk_out_valid && k < 300) begin
      @(negedge clock);
      k++;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (blk_out_valid !== 1'b1 ||
          blk_out !== 128'h101112131415161718191A1B1C1D1E1F) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: got %0d bad cycles expected 0", bad);
    end
    n_tests++;
    if (clr_cnt - c0 != 16 || rx_rdy !== 1'b1 || rx_data !== 8'hAA) begin
      n_fail++;
      $display("FAIL hold_pending: got clr=%0d rdy=%b data=%h expected 16 1 aa",
               clr_cnt - c0, rx_rdy, rx_data);
    end
    @(posedge clock); #1;
    blk_out_ready = 1'b1;
    wait_queues(1'b1, 1'b0, 500, ok);
    repeat (3) @(negedge clock);
    n_tests++;
    if (!ok || clr_cnt - c0 != 32) begin
      n_fail++;
      $display("FAIL hold_release: got pending=%0d clr=%0d expected 0 32",
               rx_exp.size(), clr_cnt - c0);
    end
  endtask

  task automatic test_timeout();
    int c0, d0, k;
    bit ok;
    @(posedge clock); #1;
    c0 = clr_cnt;
    d0 = drop_cnt;
    for (int i = 0; i < 5; i++) rx_src.push_back(8'h70 + 8'(i));
    k = 0;
    while (drop_cnt == d0 && k < 400) begin
      @(negedge clock);
      k++;
    end
    n_tests++;
    if (drop_cnt - d0 != 1 || drop_at != TO || clr_cnt - c0 != 5) begin
      n_fail++;
      $display("FAIL timeout_drop: got drops=%0d at=%0d clr=%0d expected 1 %0d 5",
               drop_cnt - d0, drop_at, clr_cnt - c0, TO);
    end
    repeat (2) @(negedge clock);
    n_tests++;
    if (drop_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL timeout_pulse: got %0d drops expected 1", drop_cnt - d0);
    end
    rx_exp.push_back(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    push_bytes(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 16, 1'b0);
    wait_queues(1'b1, 1'b0, 500, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_clean: got %0d blocks pending expected 0", rx_exp.size());
    end
  endtask

  task automatic test_tx_basic();
    int w0, k;
    bit ok, acc;
    tx_len = 4;
    w0 = wr_cnt;
    for (int i = 0; i < 16; i++) tx_exp.push_back(8'h11 * 8'(i));
    send_block(128'h00112233445566778899AABBCCDDEEFF, acc);
    wait_queues(1'b0, 1'b1, 1000, ok);
    k = 0;
    while ((tx_busy || !blk_in_ready) && k < 50) begin
      @(negedge clock);
      k++;
    end
    repeat (2) @(negedge clock);
    n_tests++;
    if (!acc || !ok || wr_cnt - w0 != 16) begin
      n_fail++;
      $display("FAIL tx_basic: got acc=%b done=%b wr=%0d expected 1 1 16",
               acc, ok, wr_cnt - w0);
    end
    n_tests++;
    if (blk_in_ready !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_ready_after: got ready=%b busy=%b expected 1 0",
               blk_in_ready, tx_busy);
    end
  endtask

  task automatic test_concurrent();
    int w0, c0;
    bit ok, acc;
    tx_len = 10;
    w0 = wr_cnt;
    c0 = clr_cnt;
    push_bytes(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 16, 1'b1);
    rx_exp.push_back(128'h303132333435363738393A3B3C3D3E3F);
    for (int i = 0; i < 16; i++) rx_src.push_back(8'h30 + 8'(i));
    send_block(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, acc);
    wait_queues(1'b1, 1'b1, 3000, ok);
    repeat (15) @(negedge clock);
    n_tests++;
    if (!acc || !ok || wr_cnt - w0 != 16 || clr_cnt - c0 != 16) begin
      n_fail++;
      $display("FAIL concurrent: got acc=%b done=%b wr=%0d clr=%0d expected 1 1 16 16",
               acc, ok, wr_cnt - w0, clr_cnt - c0);
    end
  endtask

  task automatic test_reset_mid();
    int w0, c0, w1, k;
    bit ok, acc;
    tx_len = 10;
    w0 = wr_cnt;
    c0 = clr_cnt;
    push_bytes(128'h8899AABBCCDDEEFF0011223344556677, 16, 1'b1);
    for (int i = 0; i < 7; i++) rx_src.push_back(8'h90 + 8'(i));
    send_block(128'h8899AABBCCDDEEFF0011223344556677, acc);
    k = 0;
    while ((clr_cnt - c0 < 7 || wr_cnt - w0 < 3) && k < 500) begin
      @(negedge clock);
      k++;
    end
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({tx_wr_en, rx_rdy_clr, blk_out_valid, blk_in_ready} !== 4'b0 ||
        blk_out !== '0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: got ctl=%b blk=%h tx=%h expected 0",
               {tx_wr_en, rx_rdy_clr, blk_out_valid, blk_in_ready}, blk_out, tx_data);
    end
    n_tests++;
    if (clr_cnt - c0 != 7 || wr_cnt - w0 != 3) begin
      n_fail++;
      $display("FAIL reset_point: got clr=%0d wr=%0d expected 7 3",
               clr_cnt - c0, wr_cnt - w0);
    end
    tx_exp.delete();
    rx_src.delete();
    w1 = wr_cnt;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    rx_exp.push_back(128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF);
    push_bytes(128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF, 16, 1'b0);
    wait_queues(1'b1, 1'b0, 500, ok);
    repeat (5) @(negedge clock);
    n_tests++;
    if (!ok || wr_cnt != w1 || tx_busy !== 1'b0 || blk_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fresh: got done=%b extra_wr=%0d busy=%b ready=%b expected 1 0 0 1",
               ok, wr_cnt - w1, tx_busy, blk_in_ready);
    end
    n_tests++;
    if (drop_cnt != 1) begin
      n_fail++;
      $display("FAIL drop_total: got %0d expected 1", drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_hold();
    test_timeout();
    test_tx_basic();
    test_concurrent();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
